// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, a link write, per-register
// busy scoreboard and optional same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = 31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       link_en,
    input  logic [DATA_W-1:0]          link_pc,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0]  iss_hit;

    function automatic logic [DATA_W-1:0] link_value(input logic [DATA_W-1:0] pc);
        return pc + DATA_W'(4);
    endfunction

    // Per-address winner: link beats port 1 beats port 0; nothing lands on
    // register 0 and nothing is accepted while reset is held.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            wr_hit[a]  = 1'b0;
            wr_val[a]  = '0;
            iss_hit[a] = 1'b0;
            if (a != 0 && rst_n) begin
                if (link_en && LINK_IDX == ADDR_W'(a)) begin
                    wr_hit[a] = 1'b1;
                    wr_val[a] = link_value(link_pc);
                end else if (we1 && waddr1 == ADDR_W'(a)) begin
                    wr_hit[a] = 1'b1;
                    wr_val[a] = wdata1;
                end else if (we0 && waddr0 == ADDR_W'(a)) begin
                    wr_hit[a] = 1'b1;
                    wr_val[a] = wdata0;
                end
                iss_hit[a] = iss_en && (iss_addr == ADDR_W'(a));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
            busy <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_hit[a]) begin
                    mem[a] <= wr_val[a];
                end
                // A new issue outranks the completing write: the new producer owns the register.
                if (iss_hit[a]) begin
                    busy[a] <= 1'b1;
                end else if (wr_hit[a]) begin
                    busy[a] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] d;
            logic              b;
            ra = raddr[k*ADDR_W +: ADDR_W];
            d  = mem[ra];
            b  = busy[ra];
            if (BYPASS != 0 && wr_hit[ra]) begin
                d = wr_val[ra];
                b = iss_hit[ra] ? busy[ra] : 1'b0;
            end
            if (ra == '0) begin
                d = '0;
                b = 1'b0;
            end
            rdata[k*DATA_W +: DATA_W] = d;
            rbusy[k]                  = b;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing instance (link to 31) and a registered
// instance (link to 7) share stimulus and are checked against an array model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0, we1, link_en, iss_en;
    logic [4:0]  waddr0, waddr1, iss_addr;
    logic [31:0] wdata0, wdata1, link_pc;
    logic [9:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .LINK_REG(31)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .link_en(link_en), .link_pc(link_pc),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .LINK_REG(7)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .link_en(link_en), .link_pc(link_pc),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: index 0 = bypassing/link 31, index 1 = registered/link 7.
    logic [31:0] m   [2][32];
    logic        bsy [2][32];
    logic [4:0]  lr  [2] = '{5'd31, 5'd7};
    bit          byp [2] = '{1'b1, 1'b0};

    // Later assignments in the same step override earlier ones, which gives
    // link > port 1 > port 0, and a new issue overriding a completing write.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int a = 0; a < 32; a++) begin
                    m[i][a]   <= 32'd0;
                    bsy[i][a] <= 1'b0;
                end
            end else begin
                if (we0)     begin m[i][waddr0] <= wdata0;          bsy[i][waddr0] <= 1'b0; end
                if (we1)     begin m[i][waddr1] <= wdata1;          bsy[i][waddr1] <= 1'b0; end
                if (link_en) begin m[i][lr[i]]  <= link_pc + 32'd4; bsy[i][lr[i]]  <= 1'b0; end
                if (iss_en)  bsy[i][iss_addr] <= 1'b1;
                m[i][0]   <= 32'd0;
                bsy[i][0] <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_data(int i, logic [4:0] a);
        logic [31:0] v;
        v = m[i][a];
        if (a == 5'd0 || !rst_n) return 32'd0;
        if (byp[i]) begin
            if (we0 && waddr0 == a)    v = wdata0;
            if (we1 && waddr1 == a)    v = wdata1;
            if (link_en && lr[i] == a) v = link_pc + 32'd4;
        end
        return v;
    endfunction

    function automatic logic exp_busy(int i, logic [4:0] a);
        logic wrote;
        if (a == 5'd0 || !rst_n) return 1'b0;
        wrote = (we0 && waddr0 == a) || (we1 && waddr1 == a) || (link_en && lr[i] == a);
        if (byp[i] && wrote && !(iss_en && iss_addr == a)) return 1'b0;
        return bsy[i][a];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(int inst, int k);
        return (inst == 0) ? rdata_a[k*32 +: 32] : rdata_b[k*32 +: 32];
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0] a;
            a = raddr[k*5 +: 5];
            chk($sformatf("model_rdata_a p%0d r%0d", k, a), rdata_a[k*32 +: 32], exp_data(0, a));
            chk($sformatf("model_rdata_b p%0d r%0d", k, a), rdata_b[k*32 +: 32], exp_data(1, a));
            chk($sformatf("model_rbusy_a p%0d r%0d", k, a), 32'(rbusy_a[k]), 32'(exp_busy(0, a)));
            chk($sformatf("model_rbusy_b p%0d r%0d", k, a), 32'(rbusy_b[k]), 32'(exp_busy(1, a)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; link_en = 1'b0; iss_en = 1'b0;
    endtask

    task automatic setr(logic [4:0] a0, logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        idle();
        waddr0 = '0; waddr1 = '0; iss_addr = '0;
        wdata0 = '0; wdata1 = '0; link_pc = '0;
        setr(5'd5, 5'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_rdata", rdata_a[31:0], 32'd0);
        chk("reset_rbusy", 32'(rbusy_a), 32'd0);

        // Writes held during reset are ignored, then commit on the first edge after release.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55; setr(5'd3, 5'd3);
        step(); #2;
        chk("rst_write_gated_a", rd(0, 0), 32'd0);
        step();
        rst_n = 1'b1;
        #2;
        chk("first_write_bypass_a", rd(0, 0), 32'h55);
        chk("first_write_pending_b", rd(1, 0), 32'd0);
        step(); idle(); #2;
        chk("first_write_commit_b", rd(1, 0), 32'h55);

        // Bypass of a fresh write; register 0 reads 0.
        step();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; setr(5'd5, 5'd0);
        #2;
        chk("bypass_same_cycle_a", rd(0, 0), 32'hDEADBEEF);
        chk("reg0_reads_zero_a", rd(0, 1), 32'd0);
        chk("nobypass_old_b", rd(1, 0), 32'd0);
        step(); idle(); #2;
        chk("stored_a", rd(0, 0), 32'hDEADBEEF);
        chk("stored_b", rd(1, 0), 32'hDEADBEEF);

        // Three-way collision on register 7 (link target in instance b).
        step();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        link_en = 1'b1; link_pc = 32'h100;
        step(); idle(); setr(5'd7, 5'd31); #2;
        chk("link_wins_b", rd(1, 0), 32'h104);
        chk("port1_wins_a", rd(0, 0), 32'h22);
        chk("link_r31_a", rd(0, 1), 32'h104);
        step();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        step(); idle(); #2;
        chk("port1_wins_b", rd(1, 0), 32'h22);

        // Link address wraps.
        step();
        link_en = 1'b1; link_pc = 32'hFFFFFFFC;
        step(); idle(); #2;
        chk("link_wrap_a", rd(0, 1), 32'd0);
        chk("link_wrap_b", rd(1, 0), 32'd0);

        // Scoreboard on register 9.
        setr(5'd9, 5'd9);
        step();
        iss_en = 1'b1; iss_addr = 5'd9; #2;
        chk("issue_not_yet_a", 32'(rbusy_a), 32'd0);
        step(); idle(); #2;
        chk("issue_busy_a", 32'(rbusy_a), 32'h3);
        chk("issue_busy_b", 32'(rbusy_b), 32'h3);
        step();
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99; #2;
        chk("write_forces_free_a", 32'(rbusy_a), 32'd0);
        chk("write_still_busy_b", 32'(rbusy_b), 32'h3);
        step(); idle(); #2;
        chk("write_cleared_a", 32'(rbusy_a), 32'd0);
        chk("write_cleared_b", 32'(rbusy_b), 32'd0);
        chk("write_data_a", rd(0, 1), 32'h99);
        step();
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        iss_en = 1'b1; iss_addr = 5'd9; we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77; #2;
        chk("issue_write_same_cycle_a", 32'(rbusy_a), 32'h3);
        step(); idle(); #2;
        chk("issue_wins_a", 32'(rbusy_a), 32'h3);
        chk("issue_wins_b", 32'(rbusy_b), 32'h3);
        chk("issue_write_data_b", rd(1, 0), 32'h77);

        // Register 0 ignores writes and issues.
        step();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF; iss_en = 1'b1; iss_addr = 5'd0;
        setr(5'd0, 5'd0);
        step(); idle(); #2;
        chk("reg0_write_ignored_a", rd(0, 0), 32'd0);
        chk("reg0_never_busy_a", 32'(rbusy_a), 32'd0);

        // Different addresses in one cycle all commit.
        step();
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA0A0;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hB1B1;
        link_en = 1'b1; link_pc = 32'h1000;
        step(); idle(); setr(5'd10, 5'd11); #1;
        chk("multi_p0_a", rd(0, 0), 32'hA0A0);
        chk("multi_p1_a", rd(0, 1), 32'hB1B1);
        setr(5'd31, 5'd7); #1;
        chk("multi_link_a", rd(0, 0), 32'h1004);
        chk("multi_link_b", rd(1, 1), 32'h1004);

        // Load every register with its own index.
        for (int i = 1; i < 32; i += 2) begin
            step();
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
            we1 = (i < 31); waddr1 = 5'(i + 1); wdata1 = 32'(i + 1);
        end
        step(); idle(); setr(5'd5, 5'd30); #2;
        chk("load_r5_a", rd(0, 0), 32'd5);
        chk("load_r30_b", rd(1, 1), 32'd30);

        // Registered instance shows old value during the write cycle.
        step();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hAA; iss_en = 1'b1; iss_addr = 5'd12;
        setr(5'd3, 5'd12); #2;
        chk("nobypass_old_r3_b", rd(1, 0), 32'd3);
        chk("bypass_new_r3_a", rd(0, 0), 32'hAA);
        step(); idle(); #2;
        chk("nobypass_new_r3_b", rd(1, 0), 32'hAA);

        // Mid-cycle reset with writes pending.
        step();
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hABC; iss_en = 1'b1; iss_addr = 5'd21;
        #2 rst_n = 1'b0;
        #1;
        idle();
        for (int a = 0; a < 32; a++) begin
            setr(5'(a), 5'(31 - a));
            #1;
            chk($sformatf("reset_clear_a r%0d", a), rd(0, 0), 32'd0);
            chk($sformatf("reset_clear_b r%0d", 31 - a), rd(1, 1), 32'd0);
            chk($sformatf("reset_busy_a r%0d", a), 32'(rbusy_a), 32'd0);
        end
        step();
        rst_n = 1'b1;
        setr(5'd20, 5'd21);
        step(); #2;
        chk("reset_discard_a", rd(0, 0), 32'd0);
        chk("reset_discard_busy_a", 32'(rbusy_a), 32'd0);

        // Pseudo-random mixed traffic, checked by the per-cycle model compare.
        for (int n = 0; n < 80; n++) begin
            step();
            we0 = 1'($urandom); waddr0 = 5'($urandom); wdata0 = $urandom;
            we1 = 1'($urandom); waddr1 = 5'($urandom_range(0, 12)); wdata1 = $urandom;
            link_en = ($urandom_range(0, 3) == 0); link_pc = $urandom;
            iss_en = 1'($urandom); iss_addr = 5'($urandom_range(0, 12));
            setr(5'($urandom_range(0, 12)), ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31);
        end
        step(); idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, data width in bits.
REQ-002 Parameter ADDR_W, 5, address width; depth is 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 Parameter BYPASS, 1, 1 forwards same-cycle write data to reads, 0 gives registered data only.
REQ-005 Parameter LINK_REG, 31, register index written by the link port.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 we0, waddr0, wdata0  in  1/ADDR_W/DATA_W  write port 0.
REQ-009 we1, waddr1, wdata1  in  1/ADDR_W/DATA_W  write port 1.
REQ-010 link_en, link_pc  in  1/DATA_W  link write: stores link_pc+4 into LINK_REG.
REQ-011 iss_en, iss_addr  in  1/ADDR_W  scoreboard issue: marks a destination register busy.
REQ-012 raddr  in  NUM_RD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W].
REQ-013 rdata  out  NUM_RD*DATA_W  read data, port k in bits [k*DATA_W +: DATA_W].
REQ-014 rbusy  out  NUM_RD  scoreboard busy flag for each read address.

Function
REQ-015 Storage SHALL be 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-016 Register 0 SHALL read 0 on every port, ignore all writes, and never be marked busy.
REQ-017 Writes SHALL take effect on posedge clk; reads SHALL be combinational (zero latency).
REQ-018 Effective write source per address per cycle: link > port 1 > port 0; the losing ports are dropped for that address.
REQ-019 Writes from different ports to different addresses in the same cycle SHALL all commit.
REQ-020 Link write value SHALL be link_pc + 4 modulo 2**DATA_W (wrap, no carry out).
REQ-021 With BYPASS=1, a read of address A SHALL return the winning same-cycle write data for A, else the stored value.
REQ-022 With BYPASS=0, reads SHALL return the stored value only; new data is visible the cycle after the write.
REQ-023 Busy bit for A SHALL clear on a committed write to A (any port, including link).
REQ-024 Busy bit for A SHALL set on posedge when iss_en=1 and iss_addr=A != 0.
REQ-025 Issue and write to the same A in one cycle: busy SHALL end at 1 (the new producer wins).
REQ-026 rbusy[k] SHALL reflect the stored busy bit; with BYPASS=1, a same-cycle write to raddr k SHALL force rbusy[k]=0 unless it is issued in the same cycle.
REQ-027 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-028 rst_n=0 SHALL immediately, without clk, clear all registers and busy bits to 0; rdata and rbusy then read 0.
REQ-029 Writes and issues SHALL be ignored while rst_n=0; the first update occurs on the first posedge after rst_n rises.
REQ-030 Reset asserted mid-cycle with writes pending SHALL discard them; no partial commit.

Verification
REQ-031 Reset, we0=1 waddr0=5 wdata0=0xDEADBEEF, read port 0 addr 5 -> 0xDEADBEEF same cycle (BYPASS=1), stored afterwards; port 1 addr 0 -> 0.
REQ-032 we0 and we1 both to addr 7 (0x11, 0x22) plus link_en with LINK_REG=7, link_pc=0x100 -> reg 7 = 0x104; repeat without link -> 0x22.
REQ-033 link_pc=0xFFFFFFFC, link_en=1 -> reg 31 = 0x00000000.
REQ-034 iss_en addr 9 -> rbusy=1 next cycle; we1 to 9 -> rbusy 0 after posedge; same-cycle issue and write to 9 -> rbusy stays 1.
REQ-035 Load regs 1..31 with their index, assert rst_n=0 between clock edges -> all reads 0 immediately, busy all 0.
REQ-036 BYPASS=0 build: write 0xAA to reg 3 -> read returns old value in that cycle, 0xAA the next cycle.
